// File: rtl/piso_pkg.sv
// Shared constants for the piso transmitter: FSM encoding and counter widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package piso_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Inter-word gap counter width (GAP parameter range 0..15)
  localparam int GAP_CNT_W = 4;

  // Bit counter width: clog2(width), never below one bit
  function automatic int bitcnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_buf.sv
// Two-entry word FIFO in front of the piso shifter.
// Latency: a written word is visible on rd_data the cycle after the write edge.
// Backpressure: caller must not write when count==2 unless it also reads.
//
// Ports: clk/rst (sync, active-high), wr_en/wr_data push, rd_en pop,
//        rd_data = current head (valid when count>0), count = occupancy 0..2.
module piso_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      // simultaneous push and pop leave occupancy unchanged
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter feeding a sipo (sout -> sin, sout_en -> enable).
// Latency: word accepted at edge k has its first bit on sout (sout_en=1) after edge k+1.
// Backpressure: in_ready drops when the 2-entry buffer is full; pause stalls shifting.
//
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready word handshake;
//        pause stall request; sout/sout_en serial bit + strobe (registered);
//        frame_done pulse with the last bit of a word; busy = buffered/shifting/gap.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pause,
  output logic             sout,
  output logic             sout_en,
  output logic             frame_done,
  output logic             busy
);

  localparam int BCW = bitcnt_w(WIDTH);
  localparam logic [BCW-1:0]       LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [BCW-1:0]       PENULT   = BCW'(WIDTH - 2);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP - 1);

  logic [1:0]           state, state_nxt;
  logic [WIDTH-1:0]     shreg;
  logic [BCW-1:0]       bitcnt;
  logic [GAP_CNT_W-1:0] gapcnt;

  logic [WIDTH-1:0] head;
  logic [1:0]       count;
  logic             wr_en;
  logic             load;      // pop head and put its first bit on the wire
  logic             advance;   // put the next bit of the current word on the wire
  logic             load_ok;
  logic             last;
  logic             gap_last;
  logic             nxt_sout, nxt_en, nxt_fd;

  assign in_ready = (count != 2'd2) && !rst;
  assign wr_en    = in_valid && in_ready;
  assign busy     = (count != 2'd0) || (state != ST_IDLE);

  piso_buf #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (load),
    .rd_data (head),
    .count   (count)
  );

  // bitcnt is the index of the bit already placed on sout for the current word,
  // so "last" means the final bit is on the wire and the word is complete.
  assign load_ok  = (count != 2'd0) && !pause;
  assign last     = (bitcnt == LAST_BIT);
  assign gap_last = (gapcnt == GAP_LAST);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        load      = load_ok;
        state_nxt = load_ok ? ST_SHIFT : ST_IDLE;
      end
      ST_SHIFT: begin
        if (last) begin
          if (GAP > 0) begin
            state_nxt = ST_GAP;
          end else begin
            // back-to-back: next word's first bit follows with no bubble
            load      = load_ok;
            state_nxt = load_ok ? ST_SHIFT : ST_IDLE;
          end
        end else begin
          advance = !pause;
        end
      end
      ST_GAP: begin
        // final gap cycle hands over directly so exactly GAP idle cycles appear
        if (gap_last) begin
          load      = load_ok;
          state_nxt = load_ok ? ST_SHIFT : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: next values of the registered serial outputs
  always_comb begin
    nxt_sout = 1'b0;
    nxt_en   = 1'b0;
    nxt_fd   = 1'b0;
    if (load) begin
      nxt_sout = MSB_FIRST ? head[WIDTH-1] : head[0];
      nxt_en   = 1'b1;
    end else if (advance) begin
      nxt_sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      nxt_en   = 1'b1;
      nxt_fd   = (bitcnt == PENULT);
    end else if ((state == ST_SHIFT) && !last) begin
      // paused mid-word: keep the current bit on the wire
      nxt_sout = sout;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      sout       <= 1'b0;
      sout_en    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sout       <= nxt_sout;
      sout_en    <= nxt_en;
      frame_done <= nxt_fd;
      // shreg holds the bits not yet sent, next one at the outgoing end
      if (load) begin
        shreg  <= MSB_FIRST ? {head[WIDTH-2:0], 1'b0} : {1'b0, head[WIDTH-1:1]};
        bitcnt <= '0;
      end else if (advance) begin
        shreg  <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        bitcnt <= bitcnt + 1'b1;
      end
      if ((state == ST_GAP) && !gap_last) gapcnt <= gapcnt + 1'b1;
      else                                gapcnt <= '0;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB-first/no-gap instance and LSB-first/GAP=3 instance.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// A small sipo model captures the serial stream of the MSB-first instance.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;

  logic [3:0] a_data = 4'h0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_sout, a_en, a_fd, a_busy;

  logic [3:0] b_data = 4'h0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_sout, b_en, b_fd, b_busy;

  logic [3:0] sipo = 4'h0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (a_en) sipo <= {sipo[2:0], a_sout};

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .pause(pause), .sout(a_sout), .sout_en(a_en), .frame_done(a_fd), .busy(a_busy)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .pause(pause), .sout(b_sout), .sout_en(b_en), .frame_done(b_fd), .busy(b_busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0]  w4;
    logic [7:0]  w8;
    logic [11:0] w12;
    logic [10:0] b_en_exp, b_bit_exp;
    logic [5:0]  st_en, st_bit, st_fd;

    // ---------------- reset ----------------
    rst = 1'b1;
    step; step;
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_en", a_en, 1'b0);
    chk("rst_sout", a_sout, 1'b0);
    chk("rst_fd", a_fd, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_ready_b", b_ready, 1'b0);
    rst = 1'b0;
    step;
    chk("ready_after_rst", a_ready, 1'b1);
    chk("ready_after_rst_b", b_ready, 1'b1);

    // ---------------- basic frame 1011 ----------------
    a_data = 4'b1011; a_valid = 1'b1;
    step;                                   // accept edge
    a_valid = 1'b0;
    chk("basic_busy_buffered", a_busy, 1'b1);
    chk("basic_en_before", a_en, 1'b0);
    w4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("basic_en", a_en, 1'b1);
      chk("basic_bit", a_sout, w4[3-i]);
      chk("basic_fd", a_fd, (i == 3) ? 1'b1 : 1'b0);
    end
    step;
    chk("basic_en_after", a_en, 1'b0);
    chk("basic_sout_after", a_sout, 1'b0);
    chk("basic_busy_after", a_busy, 1'b0);
    chk("basic_sipo", sipo, 4'b1011);

    // ---------------- back-to-back A then 5 ----------------
    a_data = 4'hA; a_valid = 1'b1;
    step;
    chk("b2b_ready_second", a_ready, 1'b1);
    a_data = 4'h5;
    step;                                   // accepts 5, first bit of A on wire
    a_valid = 1'b0;
    w8 = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step;
      chk("b2b_en", a_en, 1'b1);
      chk("b2b_bit", a_sout, w8[7-i]);
      chk("b2b_fd", a_fd, (i == 3 || i == 7) ? 1'b1 : 1'b0);
    end
    step;
    chk("b2b_en_after", a_en, 1'b0);

    // ---------------- stall inside a word (C) ----------------
    a_data = 4'hC; a_valid = 1'b1;
    step;
    a_valid = 1'b0;
    st_en  = 6'b110011;
    st_bit = 6'b111100;
    st_fd  = 6'b000001;
    for (int i = 0; i < 6; i++) begin
      pause = (i == 2 || i == 3);
      step;
      chk("stall_en", a_en, st_en[5-i]);
      chk("stall_bit", a_sout, st_bit[5-i]);
      chk("stall_fd", a_fd, st_fd[5-i]);
    end
    pause = 1'b0;
    step;
    chk("stall_en_after", a_en, 1'b0);
    chk("stall_busy_after", a_busy, 1'b0);

    // ---------------- backpressure with pause in IDLE ----------------
    pause = 1'b1;
    a_data = 4'h6; a_valid = 1'b1;
    chk("full_ready0", a_ready, 1'b1);
    step;
    a_data = 4'h9;
    chk("full_ready1", a_ready, 1'b1);
    step;
    a_data = 4'h3;
    chk("full_ready2", a_ready, 1'b0);
    step;
    chk("full_ready_held", a_ready, 1'b0);
    chk("full_en_paused", a_en, 1'b0);
    chk("full_busy", a_busy, 1'b1);
    pause = 1'b0;
    step;                                   // head popped, 3 still refused this edge
    chk("full_ready_reopen", a_ready, 1'b1);
    w12 = 12'b0110_1001_0011;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        step;
        a_valid = 1'b0;
      end
      chk("full_en", a_en, 1'b1);
      chk("full_bit", a_sout, w12[11-i]);
      chk("full_fd", a_fd, (i == 3 || i == 7 || i == 11) ? 1'b1 : 1'b0);
    end
    step;
    chk("full_en_after", a_en, 1'b0);
    chk("full_busy_after", a_busy, 1'b0);

    // ---------------- reset mid-word ----------------
    a_data = 4'hF; a_valid = 1'b1;
    step;
    a_data = 4'h7;
    step;                                   // first bit of F, 7 buffered
    a_valid = 1'b0;
    step;                                   // second bit of F
    chk("mid_en_before", a_en, 1'b1);
    rst = 1'b1;
    step;
    chk("mid_en", a_en, 1'b0);
    chk("mid_sout", a_sout, 1'b0);
    chk("mid_busy", a_busy, 1'b0);
    chk("mid_fd", a_fd, 1'b0);
    chk("mid_ready_in_rst", a_ready, 1'b0);
    rst = 1'b0;
    step;
    chk("mid_ready_after", a_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("mid_quiet_en", a_en, 1'b0);
      chk("mid_quiet_fd", a_fd, 1'b0);
    end
    a_data = 4'h3; a_valid = 1'b1;
    step;
    a_valid = 1'b0;
    w4 = 4'h3;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("mid_new_en", a_en, 1'b1);
      chk("mid_new_bit", a_sout, w4[3-i]);
      chk("mid_new_fd", a_fd, (i == 3) ? 1'b1 : 1'b0);
    end
    step;
    chk("mid_new_sipo", sipo, 4'h3);

    // ---------------- GAP=3, LSB first: 1 then 8 ----------------
    b_data = 4'h1; b_valid = 1'b1;
    step;
    b_data = 4'h8;
    step;                                   // first bit of 1 on wire, 8 accepted
    b_valid = 1'b0;
    b_en_exp  = 11'b1111_000_1111;
    b_bit_exp = 11'b1000_000_0001;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step;
      chk("gap_en", b_en, b_en_exp[10-i]);
      chk("gap_bit", b_sout, b_bit_exp[10-i]);
      chk("gap_fd", b_fd, (i == 3 || i == 10) ? 1'b1 : 1'b0);
      if (i == 5) chk("gap_busy_mid", b_busy, 1'b1);
    end
    step;
    chk("gap_tail_en", b_en, 1'b0);
    chk("gap_tail_busy", b_busy, 1'b1);
    step; step; step;
    chk("gap_tail_idle", b_busy, 1'b0);
    chk("gap_tail_sout", b_sout, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
